// File: rtl/stream_pkg.sv
// Shared stream constants: channel select encodings and default payload width.
package stream_pkg;

  localparam int   DW_DEFAULT = 8;
  localparam logic SEL_CH0    = 1'b0;
  localparam logic SEL_CH1    = 1'b1;

endpackage

// File: rtl/stream_mux2x1_rr_if.sv
// Bundle of the two source channels and the merged output channel of stream_mux2x1_rr.
interface stream_mux2x1_rr_if
  import stream_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  // A beat moves on a rising clk edge where valid && ready. A source holds
  // valid without looking at ready; ready may depend on valid.
  logic          in0_valid;
  logic [DW-1:0] in0_data;
  logic          in0_ready;
  logic          in1_valid;
  logic [DW-1:0] in1_data;
  logic          in1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic          out_ready;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/stream_mux2x1_rr_arb2.sv
// Combinational two-requester arbiter, one-hot grant. Round-robin by default;
// STREAM_MUX2X1_FIXED_PRIO_EN selects fixed priority with channel 0 on top.
module rr_arb2
  import stream_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

`ifdef STREAM_MUX2X1_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
`ifdef STREAM_MUX2X1_FIXED_PRIO_EN
        2'b11:   gnt = 2'b01;
`else
        // On contention the channel that did not win last time goes next.
        2'b11:   gnt = (last_grant == SEL_CH1) ? 2'b01 : 2'b10;
`endif
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/stream_mux2x1_rr.sv
// Two-source to one-sink stream merge with a registered output and out_sel tag.
// Build option STREAM_MUX2X1_FIXED_PRIO_EN swaps round-robin for fixed priority.
module stream_mux2x1_rr
  import stream_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stream_mux2x1_rr_if.slave       bus
);

  logic          out_valid_q,  out_valid_d;
  logic [DW-1:0] out_data_q,   out_data_d;
  logic          out_sel_q,    out_sel_d;
  logic          last_grant_q, last_grant_d;
  logic          load_ok;
  logic [1:0]    gnt;
  logic          xfer0, xfer1;

  // The register can take a new beat when empty or when its beat leaves this cycle.
  assign load_ok = !out_valid_q || bus.out_ready;

  rr_arb2 u_arb (
    .req        ({bus.in1_valid, bus.in0_valid}),
    .last_grant (last_grant_q),
    .enable     (load_ok && rst_n),
    .gnt        (gnt)
  );

  assign bus.in0_ready = gnt[0];
  assign bus.in1_ready = gnt[1];
  assign xfer0         = bus.in0_valid && gnt[0];
  assign xfer1         = bus.in1_valid && gnt[1];

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (xfer0) begin
      out_valid_d  = 1'b1;
      out_data_d   = bus.in0_data;
      out_sel_d    = SEL_CH0;
      last_grant_d = SEL_CH0;
    end else if (xfer1) begin
      out_valid_d  = 1'b1;
      out_data_d   = bus.in1_data;
      out_sel_d    = SEL_CH1;
      last_grant_d = SEL_CH1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= SEL_CH0;
      last_grant_q <= SEL_CH1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/stream_mux2x1_rr.md
Name: stream_mux2x1_rr

Overview:
- Two-input to one-output stream multiplexer; the inverse direction of the team's 1x2 demultiplexer.
- Merges two valid/ready source channels onto one registered output channel.
- Arbitration is round-robin. The output carries a tag (`out_sel`) naming the source, so a downstream 1x2 demux can route beats back by `out_sel`.
- Sits between two producers and a single shared consumer.

Parameters:
- DW, 8, data width of each input and of the output.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low; sampled on rising clk edge.
- in0_valid  in  1  channel 0 beat available.
- in0_data  in  DW  channel 0 payload.
- in0_ready  out  1  channel 0 beat accepted this cycle when high with in0_valid.
- in1_valid  in  1  channel 1 beat available.
- in1_data  in  DW  channel 1 payload.
- in1_ready  out  1  channel 1 beat accepted this cycle when high with in1_valid.
- out_valid  out  1  output register holds a beat.
- out_data  out  DW  output payload.
- out_sel  out  1  source of the current beat (0 = in0, 1 = in1).
- out_ready  in  1  consumer accepts the beat when high with out_valid.

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_sel=0, internal last_grant=1, so ch0 wins the first contest.
  - in0_ready and in1_ready are 0 while rst_n is low.
  - A beat in flight is discarded.
- load_ok = !out_valid || out_ready (output register empty, or draining this cycle).
- Grant (combinational):
  - only in0_valid -> ch0.
  - only in1_valid -> ch1.
  - both valid -> channel != last_grant.
  - neither valid -> none.
- inX_ready = load_ok && grant==X && rst_n.
  - Never both high in one cycle.
  - inX_ready may depend on inX_valid; sources must not make valid depend on ready.
- Transfer on a clk edge where inX_valid && inX_ready:
  - out_data <= inX_data; out_sel <= X; out_valid <= 1; last_grant <= X.
- Output handshake:
  - out_valid && out_ready with no new load -> out_valid <= 0.
  - Simultaneous drain and load -> register takes the new beat; out_valid stays 1. This gives full throughput: one beat per cycle.
- Stall: out_valid && !out_ready -> out_data, out_sel and out_valid held stable; both in*_ready = 0.
- Latency: input accept to out_valid = 1 cycle.
- Fairness: both sources continuously valid with out_ready=1 -> strict alternation 0,1,0,1.
  - Neither source waits more than one granted beat of the other.
- last_grant changes only on an actual transfer, never on an idle or stalled cycle.
- No beat may be dropped or duplicated.
- The block has no state machine beyond the output-register occupancy bit and last_grant.

Optional Feature:
- Macro: STREAM_MUX2X1_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority. Ch0 always wins when both are valid; last_grant is unused and alternation is not guaranteed (ch1 may starve).
- Undefined (default): round-robin as above.
- All other handshake, latency and reset behaviour is identical in both builds.

Decomposition:
- Shared package `stream_pkg`:
  - localparam SEL_CH0=1'b0, SEL_CH1=1'b1.
  - default DW constant.
- Sub-module `rr_arb2`, combinational 2-requester arbiter:
  - inputs: req[1:0], last_grant, enable.
  - output: one-hot gnt[1:0].
  - fixed-priority variant selected under the macro.
- The top holds the output register and last_grant.

Test Plan:
- Reset: hold rst_n=0 3 cycles with both valids high -> out_valid=0, out_data=0x00, out_sel=0, in0_ready=in1_ready=0. First grant after release goes to ch0.
- Single source: in0_valid=1, in0_data=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_sel=0; in1_ready stays 0 throughout.
- Contention: both valid, in0_data=0x11, in1_data=0x22 held, out_ready=1 for 4 cycles -> out_data sequence 0x11,0x22,0x11,0x22 with out_sel 0,1,0,1 (fixed-prio build: 0x11 x4, out_sel all 0).
- Back-pressure: load 0x3C from ch1, out_ready=0 for 5 cycles with in0_valid=1 -> out_data=0x3C, out_sel=1 stable; in0_ready=0. Raising out_ready -> 0x3C consumed and ch0 beat loaded on the same edge (out_valid never drops).
- Reset mid-stream: out_valid=1 holding 0x7E, assert rst_n=0 for 1 cycle -> out_valid=0 next cycle, beat discarded. After release, last_grant=1, so ch0 wins if both valid.
- Throughput/scoreboard: 200 random beats per channel with random valids and out_ready -> every beat appears exactly once, per-channel order preserved, out_sel matches source, no cycle with both in*_ready high.
